// File: rtl/pong_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : pong_frame_sched
// Purpose  : Once-per-frame paddle commit and ball step for the pong datapath,
//            published atomically to the renderer with a one-cycle tick.
// Revision : 1.0 - initial release
// ============================================================================
module pong_frame_sched #(
    parameter int COORDWID = 10,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PADDLE_X = 16,
    parameter int PADDLE_W = 8,
    parameter int PADDLE_H = 64,
    parameter int BALL_SZ  = 8,
    parameter int BALL_SPD = 2
) (
    input  logic                i_clk,
    input  logic                n_btn_rst,
    input  logic                i_valid,
    input  logic [COORDWID-1:0] i_data,
    input  logic                n_vsync,
    input  logic                i_enable,
    output logic [COORDWID-1:0] o_paddle_y,
    output logic [COORDWID-1:0] o_ball_x,
    output logic [COORDWID-1:0] o_ball_y,
    output logic [3:0]          o_miss_cnt,
    output logic                o_frame_tick
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_PADDLE = 3'd1;
    localparam logic [2:0] c_BALL_X = 3'd2;
    localparam logic [2:0] c_BALL_Y = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam logic [COORDWID:0] c_HRES     = (COORDWID+1)'(H_RES);
    localparam logic [COORDWID:0] c_VRES     = (COORDWID+1)'(V_RES);
    localparam logic [COORDWID:0] c_SZ       = (COORDWID+1)'(BALL_SZ);
    localparam logic [COORDWID:0] c_SPD      = (COORDWID+1)'(BALL_SPD);
    localparam logic [COORDWID:0] c_PH       = (COORDWID+1)'(PADDLE_H);
    localparam logic [COORDWID:0] c_P        = (COORDWID+1)'(PADDLE_X + PADDLE_W);
    localparam logic [COORDWID:0] c_PAD_MAX  = (COORDWID+1)'(V_RES - PADDLE_H);
    localparam logic [COORDWID:0] c_PAD_INIT = (COORDWID+1)'((V_RES - PADDLE_H) / 2);
    localparam logic [COORDWID:0] c_X_MAX    = (COORDWID+1)'(H_RES - BALL_SZ);
    localparam logic [COORDWID:0] c_Y_MAX    = (COORDWID+1)'(V_RES - BALL_SZ);
    localparam logic [COORDWID:0] c_SERVE_X  = (COORDWID+1)'((H_RES - BALL_SZ) / 2);
    localparam logic [COORDWID:0] c_SERVE_Y  = (COORDWID+1)'((V_RES - BALL_SZ) / 2);

    logic [2:0]          r_state;
    logic                r_vs_prev;
    logic [COORDWID-1:0] r_pend;
    logic                r_pend_v;
    logic [COORDWID-1:0] r_paddle_y;
    logic [COORDWID-1:0] r_ball_x;
    logic [COORDWID-1:0] r_ball_y;
    logic                r_dx_pos;
    logic                r_dy_pos;
    logic [3:0]          r_miss_cnt;
    logic                r_skip_y;

    logic [COORDWID:0]   w_x;
    logic [COORDWID:0]   w_y;
    logic [COORDWID:0]   w_pad;
    logic [COORDWID:0]   w_pend;
    logic [COORDWID:0]   w_pend_clamp;
    logic                w_overlap;
    logic [COORDWID:0]   w_nx;
    logic                w_ndx_pos;
    logic                w_miss;
    logic [COORDWID:0]   w_ny;
    logic                w_ndy_pos;

    // Everything is widened by one bit so the bounds tests cannot wrap.
    always_comb begin
        w_x          = {1'b0, r_ball_x};
        w_y          = {1'b0, r_ball_y};
        w_pad        = {1'b0, r_paddle_y};
        w_pend       = {1'b0, r_pend};
        w_pend_clamp = (w_pend > c_PAD_MAX) ? c_PAD_MAX : w_pend;
        w_overlap    = ((w_y + c_SZ) > w_pad) && (w_y < (w_pad + c_PH));
    end

    always_comb begin
        w_nx      = w_x;
        w_ndx_pos = r_dx_pos;
        w_miss    = 1'b0;
        if (r_dx_pos) begin
            if ((w_x + c_SZ + c_SPD) >= c_HRES) begin
                w_nx      = c_X_MAX;
                w_ndx_pos = 1'b0;
            end else begin
                w_nx = w_x + c_SPD;
            end
        end else if (w_x >= (c_P + c_SPD)) begin
            w_nx = w_x - c_SPD;
        end else if ((w_x >= c_P) && w_overlap) begin
            w_nx      = c_P;
            w_ndx_pos = 1'b1;
        end else if (w_x >= c_SPD) begin
            w_nx = w_x - c_SPD;
        end else begin
            w_miss = 1'b1;
        end
    end

    always_comb begin
        w_ny      = w_y;
        w_ndy_pos = r_dy_pos;
        if (r_dy_pos) begin
            if ((w_y + c_SZ + c_SPD) >= c_VRES) begin
                w_ny      = c_Y_MAX;
                w_ndy_pos = 1'b0;
            end else begin
                w_ny = w_y + c_SPD;
            end
        end else if (w_y <= c_SPD) begin
            w_ny      = '0;
            w_ndy_pos = 1'b1;
        end else begin
            w_ny = w_y - c_SPD;
        end
    end

    // A sample landing on the commit clock stays pending for the next frame.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (i_valid) begin
            r_pend   <= i_data;
            r_pend_v <= 1'b1;
        end else if (r_state == c_PADDLE) begin
            r_pend_v <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            r_state      <= c_IDLE;
            r_vs_prev    <= 1'b1;
            r_paddle_y   <= c_PAD_INIT[COORDWID-1:0];
            r_ball_x     <= c_SERVE_X[COORDWID-1:0];
            r_ball_y     <= c_SERVE_Y[COORDWID-1:0];
            r_dx_pos     <= 1'b1;
            r_dy_pos     <= 1'b1;
            r_miss_cnt   <= 4'd0;
            r_skip_y     <= 1'b0;
            o_paddle_y   <= c_PAD_INIT[COORDWID-1:0];
            o_ball_x     <= c_SERVE_X[COORDWID-1:0];
            o_ball_y     <= c_SERVE_Y[COORDWID-1:0];
            o_miss_cnt   <= 4'd0;
            o_frame_tick <= 1'b0;
        end else begin
            r_vs_prev    <= n_vsync;
            o_frame_tick <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (r_vs_prev && !n_vsync) begin
                        r_state <= c_PADDLE;
                    end
                end
                c_PADDLE: begin
                    if (r_pend_v) begin
                        r_paddle_y <= w_pend_clamp[COORDWID-1:0];
                    end
                    r_state <= c_BALL_X;
                end
                c_BALL_X: begin
                    r_skip_y <= 1'b0;
                    if (i_enable) begin
                        if (w_miss) begin
                            r_ball_x <= c_SERVE_X[COORDWID-1:0];
                            r_ball_y <= c_SERVE_Y[COORDWID-1:0];
                            r_dx_pos <= 1'b1;
                            r_dy_pos <= 1'b1;
                            r_skip_y <= 1'b1;
                            if (r_miss_cnt != 4'hF) begin
                                r_miss_cnt <= r_miss_cnt + 4'd1;
                            end
                        end else begin
                            r_ball_x <= w_nx[COORDWID-1:0];
                            r_dx_pos <= w_ndx_pos;
                        end
                    end
                    r_state <= c_BALL_Y;
                end
                c_BALL_Y: begin
                    if (i_enable && !r_skip_y) begin
                        r_ball_y <= w_ny[COORDWID-1:0];
                        r_dy_pos <= w_ndy_pos;
                    end
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    o_paddle_y   <= r_paddle_y;
                    o_ball_x     <= r_ball_x;
                    o_ball_y     <= r_ball_y;
                    o_miss_cnt   <= r_miss_cnt;
                    o_frame_tick <= 1'b1;
                    r_state      <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_frame_sched
// Purpose  : Directed plus randomized frame stimulus against a game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_frame_sched;

    logic       i_clk = 1'b0;
    logic       n_btn_rst;
    logic       i_valid;
    logic [9:0] i_data;
    logic       n_vsync;
    logic       i_enable;
    logic [9:0] o_paddle_y;
    logic [9:0] o_ball_x;
    logic [9:0] o_ball_y;
    logic [3:0] o_miss_cnt;
    logic       o_frame_tick;

    pong_frame_sched dut (
        .i_clk        (i_clk),
        .n_btn_rst    (n_btn_rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .n_vsync      (n_vsync),
        .i_enable     (i_enable),
        .o_paddle_y   (o_paddle_y),
        .o_ball_x     (o_ball_x),
        .o_ball_y     (o_ball_y),
        .o_miss_cnt   (o_miss_cnt),
        .o_frame_tick (o_frame_tick)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Game model: signed positions, velocity as +1/-1.
    int m_pad, m_x, m_y, m_vx, m_vy, m_miss, m_miss_total, m_pend;
    bit m_pendv, m_last_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pad = 208; m_x = 316; m_y = 236; m_vx = 1; m_vy = 1;
        m_miss = 0; m_miss_total = 0; m_pend = 0; m_pendv = 0; m_last_miss = 0;
    endtask

    task automatic model_frame(input bit en, input bit inj, input int d);
        bit ov;
        m_last_miss = 0;
        if (m_pendv) begin
            m_pad   = (m_pend > 416) ? 416 : m_pend;
            m_pendv = 0;
        end
        if (inj) begin
            m_pend  = d;
            m_pendv = 1;
        end
        if (!en) return;
        ov = (m_y + 8 > m_pad) && (m_y < m_pad + 64);
        if (m_vx > 0) begin
            if (m_x + 10 >= 640) begin m_x = 632; m_vx = -1; end
            else m_x += 2;
        end else if (m_x >= 26) m_x -= 2;
        else if (m_x >= 24 && ov) begin m_x = 24; m_vx = 1; end
        else if (m_x >= 2) m_x -= 2;
        else begin
            m_x = 316; m_y = 236; m_vx = 1; m_vy = 1;
            m_miss_total++;
            if (m_miss < 15) m_miss++;
            m_last_miss = 1;
        end
        if (m_last_miss) return;
        if (m_vy > 0) begin
            if (m_y + 10 >= 480) begin m_y = 472; m_vy = -1; end
            else m_y += 2;
        end else if (m_y <= 2) begin m_y = 0; m_vy = 1; end
        else m_y -= 2;
    endtask

    task automatic check_pub();
        chk("paddle_y", o_paddle_y, m_pad);
        chk("ball_x", o_ball_x, m_x);
        chk("ball_y", o_ball_y, m_y);
        chk("miss_cnt", o_miss_cnt, m_miss);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        n_btn_rst = 1'b0; i_valid = 1'b0; n_vsync = 1'b1;
        repeat (2) @(negedge i_clk);
        n_btn_rst = 1'b1;
        model_reset();
    endtask

    task automatic load(input logic [9:0] d);
        i_valid = 1'b1; i_data = d;
        m_pend = d; m_pendv = 1;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Called on a negedge with the FSM idle; E is the next posedge.
    task automatic frame(input bit en, input bit inj, input logic [9:0] d);
        logic [4:0] pat;
        pat = '0;
        i_enable = en;
        n_vsync  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (k == 0) begin
                n_vsync = 1'b1;
                if (inj) begin i_valid = 1'b1; i_data = d; end
            end
            if (k == 1) i_valid = 1'b0;
            pat[k] = o_frame_tick;
        end
        model_frame(en, inj, int'(d));
        chk("tick_at_E4", pat, 5'b10000);
        check_pub();
    endtask

    task automatic idle_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                i_valid = 1'b1; i_data = 10'($urandom);
                m_pend = int'(i_data); m_pendv = 1;
            end
            @(posedge i_clk);
            @(negedge i_clk);
            i_valid = 1'b0;
            chk("idle_no_tick", o_frame_tick, 1'b0);
            chk("idle_paddle_stable", o_paddle_y, m_pad);
            chk("idle_ball_x_stable", o_ball_x, m_x);
        end
    endtask

    initial begin
        int ticks, sx, sy, nfr;
        i_valid = 1'b0; i_data = '0; n_vsync = 1'b1; i_enable = 1'b1;
        n_btn_rst = 1'b0;
        model_reset();
        repeat (3) @(negedge i_clk);
        n_btn_rst = 1'b1;

        // Long idle with vsync high: reset values, no tick.
        ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge i_clk);
            if (o_frame_tick === 1'b1) ticks++;
        end
        chk("idle_tick_count", ticks, 0);
        chk("rst_paddle", o_paddle_y, 208);
        chk("rst_ball_x", o_ball_x, 316);
        chk("rst_ball_y", o_ball_y, 236);
        chk("rst_miss", o_miss_cnt, 0);

        // First commit and ball step.
        load(10'd100);
        frame(1'b1, 1'b0, '0);
        chk("f1_paddle", o_paddle_y, 100);
        chk("f1_ball_x", o_ball_x, 318);
        chk("f1_ball_y", o_ball_y, 238);

        // Clamp high, then zero.
        load(10'd1000);
        frame(1'b1, 1'b0, '0);
        chk("clamp_416", o_paddle_y, 416);
        load(10'd0);
        frame(1'b1, 1'b0, '0);
        chk("paddle_zero", o_paddle_y, 0);

        // Free-running wall bounces with the paddle at reset position.
        do_reset();
        for (int f = 1; f <= 160; f++) begin
            frame(1'b1, 1'b0, '0);
            if (f == 118) chk("f118_y", o_ball_y, 472);
            if (f == 119) chk("f119_y", o_ball_y, 470);
            if (f == 158) chk("f158_x", o_ball_x, 632);
        end

        // Randomized frames with idle paddle traffic and random pause.
        for (int f = 0; f < 150; f++) begin
            idle_random($urandom_range(0, 3));
            frame($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 10'($urandom));
        end

        // Sample on the commit clock stays pending.
        load(10'd80);
        frame(1'b1, 1'b1, 10'd50);
        chk("coincide_commit_old", o_paddle_y, 80);
        frame(1'b1, 1'b0, '0);
        chk("coincide_next", o_paddle_y, 50);

        // Paused ball, paddle still commits.
        sx = m_x; sy = m_y;
        load(10'd300);
        frame(1'b0, 1'b0, '0);
        chk("pause_paddle", o_paddle_y, 300);
        chk("pause_x", o_ball_x, sx);
        chk("pause_y", o_ball_y, sy);
        load(10'd5);
        frame(1'b0, 1'b0, '0);
        chk("pause_paddle2", o_paddle_y, 5);
        chk("pause_x2", o_ball_x, sx);

        // Misses with the paddle parked at 0; counter saturates.
        do_reset();
        load(10'd0);
        nfr = 0;
        while (m_miss_total < 20 && nfr < 12000) begin
            frame(1'b1, 1'b0, '0);
            nfr++;
            if (m_last_miss && m_miss_total == 1) begin
                chk("serve_x", o_ball_x, 316);
                chk("serve_y", o_ball_y, 236);
                chk("serve_miss", o_miss_cnt, 1);
            end
        end
        chk("miss_loop_bound", m_miss_total, 20);
        chk("miss_saturate", o_miss_cnt, 15);

        // Reset asserted during BALL_X: no tick, reset values.
        n_vsync = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        n_vsync = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        n_btn_rst = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        n_btn_rst = 1'b1;
        model_reset();
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            if (o_frame_tick === 1'b1) ticks++;
        end
        chk("midrst_no_tick", ticks, 0);
        check_pub();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
